// File: rtl/vga_scanout.sv
// VGA scan-out timing controller: paces a pixel source, generates sync and drives
// blanked RGB through a 2-stage aligned pipeline. Define VGASCAN_MODECHECK_EN for mode validation.
module vga_scanout #(
  parameter int BITS_PER_COLOR = 4,
  parameter int HW             = 12,
  parameter int VW             = 12
) (
  input  logic                          i_pixclk,
  input  logic                          i_reset_n,
  input  logic [HW-1:0]                 i_hm_width,
  input  logic [HW-1:0]                 i_hm_porch,
  input  logic [HW-1:0]                 i_hm_synch,
  input  logic [HW-1:0]                 i_hm_raw,
  input  logic [VW-1:0]                 i_vm_height,
  input  logic [VW-1:0]                 i_vm_porch,
  input  logic [VW-1:0]                 i_vm_synch,
  input  logic [VW-1:0]                 i_vm_raw,
  output logic                          o_rd,
  output logic                          o_newline,
  output logic                          o_newframe,
  input  logic [3*BITS_PER_COLOR-1:0]   i_pixel,
  output logic                          o_hsync,
  output logic                          o_vsync,
  output logic [BITS_PER_COLOR-1:0]     o_red,
  output logic [BITS_PER_COLOR-1:0]     o_grn,
  output logic [BITS_PER_COLOR-1:0]     o_blu,
  output logic                          o_err
);

  localparam int BPC = BITS_PER_COLOR;

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e        state_q;
  logic [HW-1:0] hwidth_q, hporch_q, hsynch_q, hraw_q;
  logic [VW-1:0] vheight_q, vporch_q, vsynch_q, vraw_q;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          h_last, v_last, frame_end, mode_ok;

  logic          rd_q, newline_q, newframe_q, hs_act_q, vs_act_q;
  logic          rd_p_q, hs_p_q, vs_p_q, hsync_q, vsync_q;
  logic [BPC-1:0] red_q, grn_q, blu_q;

  always_comb begin
    h_last    = (hpos_q == hraw_q - HW'(1));
    v_last    = (vpos_q == vraw_q - VW'(1));
    frame_end = h_last && v_last;
    hpos_d    = h_last ? '0 : hpos_q + HW'(1);
    // NOTE: vpos_d gets a default before the conditional so no path leaves it unassigned (no latch).
    vpos_d    = vpos_q;
    if (h_last) vpos_d = v_last ? '0 : vpos_q + VW'(1);
  end

`ifdef VGASCAN_MODECHECK_EN
  assign mode_ok = (i_hm_width  < i_hm_porch) && (i_hm_porch <= i_hm_synch) &&
                   (i_hm_synch <= i_hm_raw)   &&
                   (i_vm_height < i_vm_porch) && (i_vm_porch <= i_vm_synch) &&
                   (i_vm_synch <= i_vm_raw);
`else
  assign mode_ok = 1'b1;
`endif

  // Timing FSM: counters, shadow mode registers and registered strobes.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_LOAD;
      hwidth_q   <= '0;
      hporch_q   <= '0;
      hsynch_q   <= '0;
      hraw_q     <= '0;
      vheight_q  <= '0;
      vporch_q   <= '0;
      vsynch_q   <= '0;
      vraw_q     <= '0;
      hpos_q     <= '0;
      vpos_q     <= '0;
      rd_q       <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      hs_act_q   <= 1'b0;
      vs_act_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      unique case (state_q)
        ST_LOAD: begin
          hwidth_q   <= i_hm_width;
          hporch_q   <= i_hm_porch;
          hsynch_q   <= i_hm_synch;
          hraw_q     <= i_hm_raw;
          vheight_q  <= i_vm_height;
          vporch_q   <= i_vm_porch;
          vsynch_q   <= i_vm_synch;
          vraw_q     <= i_vm_raw;
          hpos_q     <= '0;
          vpos_q     <= '0;
          rd_q       <= 1'b0;
          newline_q  <= 1'b1;
          newframe_q <= 1'b1;
          hs_act_q   <= 1'b0;
          vs_act_q   <= 1'b0;
          if (mode_ok) state_q <= ST_RUN;
        end
        ST_RUN: begin
          rd_q       <= (hpos_q < hwidth_q) && (vpos_q < vheight_q);
          newline_q  <= h_last;
          newframe_q <= frame_end;
          hs_act_q   <= (hpos_q >= hporch_q) && (hpos_q < hsynch_q);
          vs_act_q   <= (vpos_q >= vporch_q) && (vpos_q < vsynch_q);
          hpos_q     <= hpos_d;
          vpos_q     <= vpos_d;
          // Mode inputs only take effect at the frame boundary.
          if (frame_end) begin
            hwidth_q  <= i_hm_width;
            hporch_q  <= i_hm_porch;
            hsynch_q  <= i_hm_synch;
            hraw_q    <= i_hm_raw;
            vheight_q <= i_vm_height;
            vporch_q  <= i_vm_porch;
            vsynch_q  <= i_vm_synch;
            vraw_q    <= i_vm_raw;
            if (!mode_ok) state_q <= ST_LOAD;
          end
        end
      endcase
    end
  end

  // Pixel returns one cycle after o_rd; sync gets the same two stages to stay aligned.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_p_q  <= 1'b0;
      hs_p_q  <= 1'b0;
      vs_p_q  <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      rd_p_q  <= rd_q;
      hs_p_q  <= hs_act_q;
      vs_p_q  <= vs_act_q;
      hsync_q <= ~hs_p_q;
      vsync_q <= ~vs_p_q;
      if (rd_p_q) begin
        red_q <= i_pixel[3*BPC-1:2*BPC];
        grn_q <= i_pixel[2*BPC-1:BPC];
        blu_q <= i_pixel[BPC-1:0];
      end else begin
        red_q <= '0;
        grn_q <= '0;
        blu_q <= '0;
      end
    end
  end

`ifdef VGASCAN_MODECHECK_EN
  logic err_q;

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      err_q <= !mode_ok;
    end else if (frame_end && !mode_ok) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_rd       = rd_q;
  assign o_newline  = newline_q;
  assign o_newframe = newframe_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_red      = red_q;
  assign o_grn      = grn_q;
  assign o_blu      = blu_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a source model feeds pixels and queues expected colors,
// a monitor pops them two cycles after o_rd; directed frames check strobe and sync timing.
module tb_vga_scanout;

  localparam int BPC = 4;
  localparam int HW  = 12;
  localparam int VW  = 12;

  logic            i_pixclk = 1'b0;
  logic            i_reset_n = 1'b1;
  logic [HW-1:0]   i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw;
  logic [VW-1:0]   i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw;
  logic            o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_err;
  logic [3*BPC-1:0] i_pixel;
  logic [BPC-1:0]  o_red, o_grn, o_blu;

  vga_scanout #(.BITS_PER_COLOR(BPC), .HW(HW), .VW(VW)) dut (
    .i_pixclk   (i_pixclk),
    .i_reset_n  (i_reset_n),
    .i_hm_width (i_hm_width),
    .i_hm_porch (i_hm_porch),
    .i_hm_synch (i_hm_synch),
    .i_hm_raw   (i_hm_raw),
    .i_vm_height(i_vm_height),
    .i_vm_porch (i_vm_porch),
    .i_vm_synch (i_vm_synch),
    .i_vm_raw   (i_vm_raw),
    .o_rd       (o_rd),
    .o_newline  (o_newline),
    .o_newframe (o_newframe),
    .i_pixel    (i_pixel),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .o_red      (o_red),
    .o_grn      (o_grn),
    .o_blu      (o_blu),
    .o_err      (o_err)
  );

  always #5 i_pixclk = ~i_pixclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source model: returns a pixel one cycle after o_rd, pushing it as the expected color.
  logic [3*BPC-1:0] exp_q[$];
  logic             pend;
  logic [3*BPC-1:0] pend_pix;
  logic [BPC-1:0]   src_h;

  always @(negedge i_pixclk) begin
    if (!i_reset_n) begin
      pend    = 1'b0;
      src_h   = '0;
      i_pixel = 12'hABC;
    end else begin
      i_pixel = pend ? pend_pix : 12'hABC;
      if (pend) exp_q.push_back(pend_pix);
      pend = o_rd;
      if (o_rd) begin
        pend_pix = {src_h, ~src_h, src_h + 4'd3};
        src_h++;
      end
      if (o_newline) src_h = '0;
    end
  end

  // Monitor: colors two cycles after o_rd come from the queue, otherwise must be blank.
  logic rd1 = 1'b0;
  logic rd2 = 1'b0;

  always @(negedge i_pixclk) begin
    if (!i_reset_n) begin
      exp_q.delete();
      rd1 = 1'b0;
      rd2 = 1'b0;
    end else begin
      if (rd2) begin
        int sz;
        sz = exp_q.size();
        check("sb_pending", sz > 0, 1);
        if (sz > 0) check("pixel_color", {o_red, o_grn, o_blu}, exp_q.pop_front());
      end else begin
        check("blank_color", {o_red, o_grn, o_blu}, 0);
      end
      rd2 = rd1;
      rd1 = o_rd;
    end
  end

  // Runs one frame starting at a negedge where o_newframe is high.
  task automatic measure_frame(input int change_at,
                               output int len, output int rd_cnt, output int vs_low,
                               output int nl_cnt, output int nl_bad, output int hs_falls,
                               output int hs_w, output int hs_off, output int first_rd);
    int   last_nl, first_hs;
    logic prev_hs, hs_done;
    len = 0; rd_cnt = 0; vs_low = 0; nl_cnt = 0; nl_bad = 0; hs_falls = 0; hs_w = 0;
    last_nl = 0; first_rd = -1; first_hs = -1; hs_done = 1'b0;
    prev_hs = o_hsync;
    do begin
      if (o_rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = len;
      end
      if (prev_hs && !o_hsync) hs_falls++;
      if (!o_hsync && first_rd >= 0 && !hs_done) begin
        if (first_hs < 0) first_hs = len;
        hs_w++;
      end else if (first_hs >= 0) begin
        hs_done = 1'b1;
      end
      prev_hs = o_hsync;
      if (!o_vsync) vs_low++;
      if (o_newline) begin
        if (len > 0 && len - last_nl != 14) nl_bad++;
        last_nl = len;
        nl_cnt++;
      end
      if (len == change_at) i_hm_width = 12'd6;
      @(negedge i_pixclk);
      len++;
    end while (!o_newframe && len < 1000);
    hs_off = first_hs - first_rd;
    check("frame_end_seen", len < 1000, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, rd_cnt, vs_low, nl_cnt, nl_bad, hs_falls, hs_w, hs_off, first_rd;
    int cnt, nf_cnt;

    i_hm_width = 12'd8;  i_hm_porch = 12'd10; i_hm_synch = 12'd12; i_hm_raw = 12'd14;
    i_vm_height = 12'd4; i_vm_porch = 12'd5;  i_vm_synch = 12'd6;  i_vm_raw = 12'd7;

    #1 i_reset_n = 1'b0;
    #1;
    check("rst_rd", o_rd, 0);
    check("rst_newline", o_newline, 0);
    check("rst_newframe", o_newframe, 0);
    check("rst_hsync", o_hsync, 1);
    check("rst_vsync", o_vsync, 1);
    check("rst_color", {o_red, o_grn, o_blu}, 0);
    check("rst_err", o_err, 0);

    repeat (3) @(negedge i_pixclk);
    i_reset_n = 1'b1;
    @(negedge i_pixclk);
    check("load_newframe", o_newframe, 1);
    check("load_newline", o_newline, 1);
    check("load_rd", o_rd, 0);

    // Frame 1: basic small-mode timing.
    measure_frame(-1, len, rd_cnt, vs_low, nl_cnt, nl_bad, hs_falls, hs_w, hs_off, first_rd);
    check("f1_first_rd_cycle", first_rd, 1);
    check("f1_len", len, 98);
    check("f1_rd_cnt", rd_cnt, 32);
    check("f1_vsync_low", vs_low, 14);
    check("f1_newlines", nl_cnt, 7);
    check("f1_newline_spacing_bad", nl_bad, 0);
    check("f1_hsync_pulses", hs_falls, 7);
    check("f1_hsync_width", hs_w, 2);
    check("f1_hsync_offset", hs_off, 12);

    // Frame 2: width changes mid-frame, must not take effect yet.
    measure_frame(40, len, rd_cnt, vs_low, nl_cnt, nl_bad, hs_falls, hs_w, hs_off, first_rd);
    check("f2_len", len, 98);
    check("f2_rd_cnt", rd_cnt, 32);
    check("f2_vsync_low", vs_low, 14);

    // Frame 3: new width in force.
    measure_frame(-1, len, rd_cnt, vs_low, nl_cnt, nl_bad, hs_falls, hs_w, hs_off, first_rd);
    check("f3_len", len, 98);
    check("f3_rd_cnt", rd_cnt, 24);
    check("f3_hsync_offset", hs_off, 12);
    i_hm_width = 12'd8;

    // Reset mid-line at hpos 5 of line 5 (vsync line).
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 5; i++) begin
      @(negedge i_pixclk);
      if (o_newline) cnt++;
    end
    check("reach_line5", cnt, 5);
    repeat (5) @(negedge i_pixclk);
    check("pre_reset_vsync", o_vsync, 0);
    i_reset_n = 1'b0;
    #1;
    check("midrst_rd", o_rd, 0);
    check("midrst_newline", o_newline, 0);
    check("midrst_newframe", o_newframe, 0);
    check("midrst_hsync", o_hsync, 1);
    check("midrst_vsync", o_vsync, 1);
    check("midrst_color", {o_red, o_grn, o_blu}, 0);
    check("midrst_err", o_err, 0);
    repeat (3) @(negedge i_pixclk);
    i_reset_n = 1'b1;
    @(negedge i_pixclk);
    check("reload_newframe", o_newframe, 1);
    check("reload_newline", o_newline, 1);
    check("reload_rd", o_rd, 0);
    @(negedge i_pixclk);
    check("reload_first_rd", o_rd, 1);
    check("reload_newframe_drop", o_newframe, 0);

`ifdef VGASCAN_MODECHECK_EN
    // Invalid mode: porch below width.
    i_reset_n = 1'b0;
    i_hm_porch = 12'd6;
    repeat (3) @(negedge i_pixclk);
    i_reset_n = 1'b1;
    @(negedge i_pixclk);
    rd_cnt = 0;
    nf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_pixclk);
      if (o_rd) rd_cnt++;
      if (o_newframe) nf_cnt++;
    end
    check("bad_mode_err", o_err, 1);
    check("bad_mode_rd_cnt", rd_cnt, 0);
    check("bad_mode_newframe_cnt", nf_cnt, 20);
    check("bad_mode_hsync", o_hsync, 1);
    i_hm_porch = 12'd10;
    @(negedge i_pixclk);
    check("fixed_mode_err", o_err, 0);
    check("fixed_mode_newframe", o_newframe, 1);
    measure_frame(-1, len, rd_cnt, vs_low, nl_cnt, nl_bad, hs_falls, hs_w, hs_off, first_rd);
    check("fixed_len", len, 98);
    check("fixed_rd_cnt", rd_cnt, 32);
`else
    repeat (4) @(negedge i_pixclk);
    check("err_tied_low", o_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
